uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx` serializer between `NREQ` byte-stream requesters, such as the command sequencer, the data sender and a debug port. Grants are round-robin and cover a whole packet, so one requester's bytes are never interleaved with another's. A programmable idle gap follows every packet. A stall timeout aborts a packet whose owner stops supplying bytes, which prevents one requester from locking out the others.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx.sv | 69 ++++++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg : baud divisors (50 MHz clock) and arbiter state encoding
//  Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int B115200 = 434;
  localparam int B57600  = 868;
  localparam int B38400  = 1302;
  localparam int B19200  = 2604;
  localparam int B9600   = 5208;
  localparam int B4800   = 10417;
  localparam int B2400   = 20833;
  localparam int B1200   = 41667;
  localparam int B600    = 83333;
  localparam int B300    = 166667;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    START = ST_START,
    DRAIN = ST_DRAIN,
    GAP   = ST_GAP,
    ABORT = ST_ABORT
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  uart_tx : 8N1 serializer, one bit every BAUD clocks, tx idles high
//  Rev 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       start,
  output logic       ready,
  output logic       tx
);

  localparam int            CW       = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD - 1);

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;

  // ready rises in the last stop-bit clock so a follow-on frame can start
  // without an extra idle clock
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    ready    = !active_q || (bit_q == 4'd9 && cnt_q == CNT_LAST);
    if (start && ready) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      cnt_d    = '0;
      frame_d  = {1'b1, data, 1'b0};
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        frame_d = {1'b1, frame_q[9:1]};
        if (bit_q == 4'd9) active_d = 1'b0;
        else               bit_d    = bit_q + 4'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      frame_q  <= '1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
    end
  end

  assign tx = frame_q[0];

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  uart_tx_arbiter : packet-granular round-robin sharing of one uart_tx,
//                    with post-packet idle gap and stall-timeout abort
//  Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BAUD       = B115200,
  parameter int GAP_CYCLES = 2500,
  parameter int STALL_MAX  = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                abort,
  output logic                tx
);

  localparam int            SW         = $clog2(STALL_MAX + 1);
  localparam int            GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  arb_state_e    state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [GW-1:0] gap_q, gap_d;

  logic            uart_ready;
  logic            uart_start;
  logic [NREQ-1:0] sel_onehot;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_byte;

  // First pending requester after p, wrapping modulo NREQ
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] v, input logic [2:0] p);
    logic            found;
    logic [NREQ-1:0] sh;
    int              idx;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        rr_pick = 3'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  assign sel_onehot = NREQ'(1) << grant_q;
  assign sel_valid  = |(req_valid & sel_onehot);
  assign sel_last   = |(req_last & sel_onehot);
  assign sel_byte   = 8'(req_data >> {grant_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    last_d     = last_q;
    stall_d    = '0;
    gap_d      = '0;
    req_ready  = '0;
    uart_start = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = rr_pick(req_valid, ptr_q);
          ptr_d   = rr_pick(req_valid, ptr_q);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid && uart_ready) begin
          req_ready = sel_onehot;
          data_d    = sel_byte;
          last_d    = sel_last;
          state_d   = START;
        end else if (stall_q == STALL_LAST) begin
          state_d = ABORT;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      START: begin
        uart_start = 1'b1;
        if (!uart_ready) state_d = DRAIN;
      end
      DRAIN: begin
        if (uart_ready) begin
          if (!last_q)               state_d = LOAD;
          else if (GAP_CYCLES == 0)  state_d = IDLE;
          else                       state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      ABORT: begin
        abort   = 1'b1;
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'(NREQ - 1);
      grant_q <= 3'd0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

  uart_tx #(
    .BAUD (BAUD)
  ) TX0 (
    .clk   (clk),
    .rstn  (rst),
    .data  (data_q),
    .start (uart_start),
    .ready (uart_ready),
    .tx    (tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_uart_tx_arbiter : directed bench, BAUD=4, GAP_CYCLES=5 / 0, STALL_MAX=100
//  Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int BAUD  = 4;
  localparam int GAP   = 5;
  localparam int STALL = 100;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_last  = '0;
  logic [8*NREQ-1:0]   req_data  = '0;
  logic [NREQ-1:0]     req_ready;
  logic [2:0]          grant_id;
  logic                busy, abort, tx;

  logic [NREQ-1:0]     vz = '0;
  logic [NREQ-1:0]     lz = '0;
  logic [NREQ-1:0]     rz;
  logic [2:0]          gid_z;
  logic                busy_z, abort_z, tx_z;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .BAUD(BAUD), .GAP_CYCLES(GAP), .STALL_MAX(STALL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id),
    .busy(busy), .abort(abort), .tx(tx)
  );

  uart_tx_arbiter #(
    .NREQ(NREQ), .BAUD(BAUD), .GAP_CYCLES(0), .STALL_MAX(STALL)
  ) dut_z (
    .clk(clk), .rst(rst), .req_valid(vz), .req_data(req_data),
    .req_last(lz), .req_ready(rz), .grant_id(gid_z),
    .busy(busy_z), .abort(abort_z), .tx(tx_z)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pq[$];
  int         gq[$];
  logic [7:0] rxq[$];
  int         abort_cnt = 0;
  int         frame_err = 0;
  bit         mon_en    = 1'b1;
  logic [7:0] mb;

  // accept pulses and abort pulses, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (|req_ready) begin
      pq.push_back(cyc);
      gq.push_back(int'(grant_id));
    end
    if (abort) abort_cnt++;
  end

  // serial line decoder: mid-bit sampling of each 4-clock bit
  initial forever begin
    @(negedge clk);
    if (mon_en && rst && tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        mb[i] = tx;
      end
      repeat (4) @(negedge clk);
      if (mon_en) begin
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(mb);
      end
    end
  end

  function automatic int pq_at(input int i);
    return (i < pq.size()) ? pq[i] : -1000;
  endfunction
  function automatic int gq_at(input int i);
    return (i < gq.size()) ? gq[i] : -1;
  endfunction
  function automatic logic [31:0] rx_at(input int i);
    return (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    pq.delete();
    gq.delete();
    rxq.delete();
    abort_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // present n bytes on requester id; stall=1 drops valid after the bytes, no last
  task automatic send_pkt(input int id, input logic [31:0] bytes, input int n, input bit stall);
    bit got;
    for (int k = 0; k < n; k++) begin
      req_data[8*id +: 8] = bytes[8*k +: 8];
      req_last[id]        = (k == n - 1) && !stall;
      req_valid[id]       = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
        @(negedge clk);
        got = req_ready[id];
      end
      chk("ready_timeout", 32'(got), 32'd1);
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic wait_busy_low(output int fc);
    bit got;
    got = 1'b0;
    fc  = -1;
    for (int t = 0; t < 600 && !got; t++) begin
      if (busy === 1'b0) begin
        got = 1'b1;
        fc  = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("busy_low_timeout", 32'(got), 32'd1);
  endtask

  int  c0, fc, ac, a;
  bit  got;
  logic [31:0] exp_rx[8];

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ---- reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_uart_start", 32'(dut.uart_start), 32'd0);

    // ---- single packet from requester 2
    clear_q();
    c0 = cyc;
    fork
      send_pkt(2, 32'h000D_5441, 3, 1'b0);
      begin
        @(negedge clk);
        chk("busy_cycle1", 32'(busy), 32'd1);
        chk("ready_cycle1", 32'(req_ready), 32'b0100);
        @(negedge clk);
        chk("start_cycle2", 32'(dut.uart_start), 32'd1);
      end
    join
    wait_busy_low(fc);
    chk("sp_ready_count", 32'(pq.size()), 32'd3);
    chk("sp_first_latency", 32'(pq_at(0) - c0), 32'd1);
    chk("sp_spacing_1", 32'(pq_at(1) - pq_at(0)), 32'd42);
    chk("sp_spacing_2", 32'(pq_at(2) - pq_at(1)), 32'd42);
    chk("sp_grant_hist", 32'(gq_at(2)), 32'd2);
    chk("sp_grant_id", 32'(grant_id), 32'd2);
    chk("sp_rx0", rx_at(0), 32'h41);
    chk("sp_rx1", rx_at(1), 32'h54);
    chk("sp_rx2", rx_at(2), 32'h0D);
    chk("sp_busy_fall", 32'(fc - pq_at(2)), 32'd47);

    // ---- simultaneous requesters 0 and 1
    do_reset();
    clear_q();
    fork
      send_pkt(0, 32'h0000_A2A1, 2, 1'b0);
      send_pkt(1, 32'h0000_B2B1, 2, 1'b0);
    join
    wait_busy_low(fc);
    chk("sim_grant0", 32'(gq_at(0)), 32'd0);
    chk("sim_grant1", 32'(gq_at(1)), 32'd0);
    chk("sim_grant2", 32'(gq_at(2)), 32'd1);
    chk("sim_grant3", 32'(gq_at(3)), 32'd1);
    chk("sim_rx0", rx_at(0), 32'hA1);
    chk("sim_rx1", rx_at(1), 32'hA2);
    chk("sim_rx2", rx_at(2), 32'hB1);
    chk("sim_rx3", rx_at(3), 32'hB2);

    // ---- fairness: 0 and 3, four one-byte packets each
    do_reset();
    clear_q();
    fork
      begin
        for (int k = 0; k < 4; k++) send_pkt(0, 32'h10 + 32'(k), 1, 1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) send_pkt(3, 32'h30 + 32'(k), 1, 1'b0);
      end
    join
    wait_busy_low(fc);
    exp_rx = '{32'h10, 32'h30, 32'h11, 32'h31, 32'h12, 32'h32, 32'h13, 32'h33};
    for (int i = 0; i < 8; i++) begin
      chk("fair_grant", 32'(gq_at(i)), (i % 2 == 0) ? 32'd0 : 32'd3);
      chk("fair_rx", rx_at(i), exp_rx[i]);
    end

    // ---- stall: requester 1 sends one byte without last, then goes quiet
    clear_q();
    send_pkt(1, 32'h55, 1, 1'b1);
    got = 1'b0;
    ac  = -1;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (abort === 1'b1) begin
        got = 1'b1;
        ac  = cyc;
      end
    end
    chk("stall_abort_timeout", 32'(got), 32'd1);
    wait_busy_low(fc);
    chk("stall_abort_cycle", 32'(ac - pq_at(0)), 32'd142);
    chk("stall_abort_count", 32'(abort_cnt), 32'd1);
    chk("stall_busy_fall", 32'(fc - pq_at(0)), 32'd148);
    chk("stall_grant_id", 32'(grant_id), 32'd1);
    chk("stall_rx0", rx_at(0), 32'h55);

    // ---- reset during the 4th data bit of 0xA5
    clear_q();
    send_pkt(2, 32'hA5, 1, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_frame_bit3", 32'(tx), 32'd0);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("mr_tx", 32'(tx), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_uart_start", 32'(dut.uart_start), 32'd0);
    chk("mr_abort", 32'(abort), 32'd0);
    chk("mr_grant_id", 32'(grant_id), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    clear_q();
    mon_en = 1'b1;
    fork
      send_pkt(0, 32'h01, 1, 1'b0);
      send_pkt(3, 32'h03, 1, 1'b0);
    join
    wait_busy_low(fc);
    chk("mr_after_grant0", 32'(gq_at(0)), 32'd0);
    chk("mr_after_grant1", 32'(gq_at(1)), 32'd3);
    chk("mr_after_rx0", rx_at(0), 32'h01);
    chk("mr_after_abort_cnt", 32'(abort_cnt), 32'd0);

    // ---- zero gap instance
    req_data[7:0] = 8'h3C;
    vz[0] = 1'b1;
    lz[0] = 1'b1;
    got = 1'b0;
    a   = -1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (rz[0] === 1'b1) begin
        got = 1'b1;
        a   = cyc;
      end
    end
    chk("zg_ready_timeout", 32'(got), 32'd1);
    @(negedge clk);
    vz[0] = 1'b0;
    lz[0] = 1'b0;
    got = 1'b0;
    fc  = -1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (busy_z === 1'b0) begin
        got = 1'b1;
        fc  = cyc;
      end
    end
    chk("zg_busy_timeout", 32'(got), 32'd1);
    chk("zg_busy_fall", 32'(fc - a), 32'd42);
    chk("zg_abort", 32'(abort_z), 32'd0);

    chk("frame_errors", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
